// File: rtl/cache_line_refill.sv
// Miss handler for a 2-way set-associative cache: writes back a dirty victim
// line word by word, then refills the chosen way from memory in word order.
module cache_line_refill #(
  parameter int WORDS_PER_LINE = 8,
  parameter int INDEX_W        = 6,
  localparam int WB            = $clog2(WORDS_PER_LINE),
  localparam int TAG_W         = 32 - INDEX_W - WB - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_req,
  input  logic [31:0]      miss_addr,
  input  logic             victim,
  input  logic             victim_valid,
  input  logic             victim_dirty,
  input  logic [TAG_W-1:0] victim_tag,
  output logic [WB-1:0]    cache_rd_word,
  input  logic [31:0]      cache_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             fill_we,
  output logic             fill_way,
  output logic [WB-1:0]    fill_word,
  output logic [31:0]      fill_data,
  output logic             fill_last,
  output logic             busy,
  output logic             done
);

  localparam int LINE_W = TAG_W + INDEX_W;

  typedef enum logic [2:0] {
    IDLE, WB_LOAD, WB_REQ, FILL_REQ, FILL_WR, DONE
  } state_t;

  state_t              state;
  logic [WB-1:0]       cnt;
  logic [LINE_W-1:0]   line_q;
  logic [TAG_W-1:0]    vtag_q;
  logic                way_q;
  logic [31:0]         wdata_q;
  logic [31:0]         fill_data_q;
  logic                last;

  // Byte/word offset of the miss address is regenerated from cnt.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[WB+1:0];

  assign last = (cnt == WB'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      line_q      <= '0;
      vtag_q      <= '0;
      way_q       <= 1'b0;
      wdata_q     <= '0;
      fill_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (miss_req) begin
          line_q <= miss_addr[31:WB+2];
          way_q  <= victim;
          vtag_q <= victim_tag;
          cnt    <= '0;
          state  <= (victim_valid && victim_dirty) ? WB_LOAD : FILL_REQ;
        end
        WB_LOAD: begin
          wdata_q <= cache_rdata;
          state   <= WB_REQ;
        end
        WB_REQ: if (mem_ack) begin
          if (last) begin
            cnt   <= '0;
            state <= FILL_REQ;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= WB_LOAD;
          end
        end
        FILL_REQ: if (mem_ack) begin
          fill_data_q <= mem_rdata;
          state       <= FILL_WR;
        end
        FILL_WR: begin
          if (last) state <= DONE;
          else begin
            cnt   <= cnt + 1'b1;
            state <= FILL_REQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they hold steady across memory waits.
  always_comb begin
    cache_rd_word = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    fill_we       = 1'b0;
    fill_way      = 1'b0;
    fill_word     = '0;
    fill_data     = '0;
    fill_last     = 1'b0;
    case (state)
      WB_LOAD: cache_rd_word = cnt;
      WB_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vtag_q, line_q[INDEX_W-1:0], cnt, 2'b00};
        mem_wdata = wdata_q;
      end
      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {line_q, cnt, 2'b00};
      end
      FILL_WR: begin
        fill_we   = 1'b1;
        fill_way  = way_q;
        fill_word = cnt;
        fill_data = fill_data_q;
        fill_last = last;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill: memory/cache-array models plus event logs.
module tb_cache_line_refill;
  localparam int N     = 8;
  localparam int WB    = 3;
  localparam int TAG_W = 21;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             miss_req = 1'b0;
  logic [31:0]      miss_addr = '0;
  logic             victim = 1'b0, victim_valid = 1'b0, victim_dirty = 1'b0;
  logic [TAG_W-1:0] victim_tag = '0;
  logic [WB-1:0]    cache_rd_word;
  logic [31:0]      cache_rdata;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic             mem_ack;
  logic             fill_we, fill_way, fill_last, busy, done;
  logic [WB-1:0]    fill_word;
  logic [31:0]      fill_data;

  logic ack_m = 1'b0, stray_ack = 1'b0;
  int   mem_lat = 0, wcnt = 0, cyc = 0, acc_cyc = 0;
  int   n_checks = 0, n_err = 0;

  cache_line_refill #(.WORDS_PER_LINE(N), .INDEX_W(6)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim(victim), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .cache_rd_word(cache_rd_word), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fill_we(fill_we), .fill_way(fill_way),
    .fill_word(fill_word), .fill_data(fill_data), .fill_last(fill_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Victim line holds 0x100+i; memory returns 0xD00D in the top half of the address.
  assign cache_rdata = 32'h100 + {29'd0, cache_rd_word};
  assign mem_ack     = ack_m | stray_ack;
  assign mem_rdata   = ack_m ? {16'hD00D, mem_addr[15:0]} : 32'h0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= mem_lat) begin ack_m = 1'b1; wcnt = 0; end
      else begin ack_m = 1'b0; wcnt++; end
    end else begin
      ack_m = 1'b0; wcnt = 0;
    end
  end

  logic [31:0] wr_addr[32], wr_data[32], rd_addr[32], fl_data[32];
  int          fl_word[32];
  logic        fl_way[32];
  int n_wr, n_rd, n_fill, n_last, last_word, seq, first_rd_seq, last_wr_seq, stab_err;
  logic        prev_req = 0, prev_ack = 0, prev_we = 0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  task automatic clear_logs();
    n_wr = 0; n_rd = 0; n_fill = 0; n_last = 0; last_word = -1;
    seq = 0; first_rd_seq = -1; last_wr_seq = -1; stab_err = 0;
  endtask

  always @(negedge clk) begin
    #1;
    if (mem_req && prev_req && !prev_ack &&
        (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_we !== prev_we))
      stab_err++;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        if (n_wr < 32) begin wr_addr[n_wr] = mem_addr; wr_data[n_wr] = mem_wdata; end
        n_wr++; last_wr_seq = seq;
      end else begin
        if (n_rd < 32) rd_addr[n_rd] = mem_addr;
        if (n_rd == 0) first_rd_seq = seq;
        n_rd++;
      end
      seq++;
    end
    if (fill_we) begin
      if (n_fill < 32) begin
        fl_word[n_fill] = int'(fill_word); fl_data[n_fill] = fill_data; fl_way[n_fill] = fill_way;
      end
      n_fill++;
    end
    if (fill_last) begin n_last++; last_word = int'(fill_word); end
    prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
    prev_addr = mem_addr; prev_wdata = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_miss(input logic [31:0] a, input logic v, input logic vv,
                            input logic vd, input logic [TAG_W-1:0] t);
    @(negedge clk);
    miss_req = 1'b1; miss_addr = a; victim = v;
    victim_valid = vv; victim_dirty = vd; victim_tag = t;
    @(posedge clk);
    @(negedge clk);
    miss_req = 1'b0; acc_cyc = cyc;
    // Victim inputs are scrambled after acceptance; they must be ignored.
    victim = ~v; victim_valid = ~vv; victim_dirty = ~vd; victim_tag = ~t;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      if (done) begin lat = cyc - acc_cyc + 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic check_fill(input logic [31:0] base, input logic way);
    chk("rd_count", n_rd, N);
    chk("fill_count", n_fill, N);
    chk("fill_last_count", n_last, 1);
    chk("fill_last_word", last_word, N - 1);
    for (int i = 0; i < N; i++) begin
      chk("rd_addr", rd_addr[i], base + 32'(4 * i));
      chk("fill_word", fl_word[i], i);
      chk("fill_way", {31'd0, fl_way[i]}, {31'd0, way});
      chk("fill_data", fl_data[i], {16'hD00D, base[15:0] + 16'(4 * i)});
    end
  endtask

  task automatic check_wb(input logic [31:0] base);
    chk("wr_count", n_wr, N);
    for (int i = 0; i < N; i++) begin
      chk("wr_addr", wr_addr[i], base + 32'(4 * i));
      chk("wr_data", wr_data[i], 32'h100 + 32'(i));
    end
    chk("wb_before_fill", {31'd0, last_wr_seq < first_rd_seq}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit hit;
    clear_logs();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem", {mem_req, mem_we, mem_addr[29:0]}, 0);
    chk("rst_fill", {fill_we, fill_way, fill_last, fill_word, cache_rd_word}, 0);
    rst = 1'b0;

    // Clean miss, way 1
    clear_logs();
    start_miss(32'h0000_1A40, 1'b1, 1'b1, 1'b0, 21'd3);
    wait_done(lat);
    chk("clean_latency", lat, 2 * N + 1);
    @(negedge clk); chk("busy_fall", busy, 0);
    check_fill(32'h0000_1A40, 1'b1);
    chk("clean_no_wr", n_wr, 0);

    // Dirty miss, way 0, old line at 0x3A40 (tag 7, same index)
    clear_logs();
    start_miss(32'h0000_1A40, 1'b0, 1'b1, 1'b1, 21'd7);
    wait_done(lat);
    chk("dirty_latency", lat, 4 * N + 1);
    @(negedge clk); chk("busy_fall", busy, 0);
    check_wb(32'h0000_3A40);
    check_fill(32'h0000_1A40, 1'b0);

    // Invalid but dirty victim: no writeback
    clear_logs();
    start_miss(32'h0000_1A40, 1'b1, 1'b0, 1'b1, 21'd7);
    wait_done(lat);
    chk("inv_latency", lat, 2 * N + 1);
    @(negedge clk);
    chk("inv_no_wr", n_wr, 0);
    check_fill(32'h0000_1A40, 1'b1);

    // Slow memory, 3 wait cycles per access, dirty miss
    mem_lat = 3;
    clear_logs();
    start_miss(32'h0000_1A40, 1'b0, 1'b1, 1'b1, 21'd7);
    wait_done(lat);
    chk("slow_latency", lat, 4 * N + 1 + 3 * 2 * N);
    @(negedge clk);
    chk("slow_stable", stab_err, 0);
    check_wb(32'h0000_3A40);
    check_fill(32'h0000_1A40, 1'b0);
    mem_lat = 0;

    // Reset while filling word 4
    clear_logs();
    start_miss(32'h0000_2460, 1'b1, 1'b1, 1'b0, 21'd4);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      if (fill_we && fill_word == 3'd4) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("reach_word4", {31'd0, hit}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_done", {busy, done}, 0);
    chk("abort_mem", {mem_req, mem_we}, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    chk("abort_fill", {fill_we, fill_way, fill_last, fill_word, cache_rd_word}, 0);
    chk("abort_fill_data", fill_data, 0);
    rst = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_busy", busy, 0);
    chk("stray_mem_req", mem_req, 0);
    chk("abort_no_last", n_last, 0);
    chk("abort_fill_count", n_fill, 5);
    clear_logs();
    start_miss(32'h0000_1A40, 1'b1, 1'b1, 1'b0, 21'd3);
    wait_done(lat);
    chk("after_rst_latency", lat, 2 * N + 1);
    @(negedge clk);
    check_fill(32'h0000_1A40, 1'b1);

    // miss_req pulse while busy is dropped
    clear_logs();
    start_miss(32'h0000_1A40, 1'b1, 1'b1, 1'b0, 21'd3);
    repeat (4) @(negedge clk);
    miss_req = 1'b1; miss_addr = 32'h0000_2460; victim_valid = 1'b1; victim_dirty = 1'b1;
    @(negedge clk); miss_req = 1'b0;
    wait_done(lat);
    chk("pulse_latency", lat, 2 * N + 1);
    repeat (10) @(negedge clk);
    chk("pulse_idle", busy, 0);
    chk("pulse_no_wr", n_wr, 0);
    chk("pulse_rd_count", n_rd, N);
    chk("pulse_rd0", rd_addr[0], 32'h0000_1A40);

    // Held miss_req restarts right after done
    clear_logs();
    @(negedge clk);
    miss_req = 1'b1; miss_addr = 32'h0000_1A40; victim = 1'b1;
    victim_valid = 1'b1; victim_dirty = 1'b0; victim_tag = 21'd3;
    @(posedge clk); @(negedge clk); acc_cyc = cyc;
    wait_done(lat);
    chk("held_latency1", lat, 2 * N + 1);
    @(negedge clk); chk("held_idle_gap", busy, 0);
    @(negedge clk); chk("held_restart", busy, 1);
    miss_req = 1'b0; acc_cyc = cyc;
    wait_done(lat);
    chk("held_latency2", lat, 2 * N + 1);
    @(negedge clk);
    chk("held_rd_count", n_rd, 2 * N);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/cache_line_refill.md
# cache_line_refill

Miss handler for the 2-way set-associative cache. It consumes the way chosen by the victim selector and evicts that line, writing it back word by word to memory when it is valid and dirty. It then refills the way from memory. It sits between the cache data/tag arrays and the memory bus, and raises `done` when the line is ready for the replayed access.

## Interface
- `WORDS_PER_LINE`, default 8: words per line (power of 2, ≥2); `WB = log2(WORDS_PER_LINE)`.
- `INDEX_W`, default 6: set index width; `TAG_W = 32 - INDEX_W - WB - 2`.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `miss_req` in 1: miss pending; sampled only in IDLE.
- `miss_addr` in 32: missing byte address.
- `victim` in 1: way to evict, from the victim selector.
- `victim_valid` in 1: valid bit of the selected way.
- `victim_dirty` in 1: dirty bit of the selected way.
- `victim_tag` in TAG_W: tag of the selected way.
- `cache_rd_word` out WB: word index into the victim line; the data array read is combinational.
- `cache_rdata` in 32: word read from (latched index, latched way, `cache_rd_word`).
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: word-aligned address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data; valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion strobe.
- `fill_we` out 1: write one word into the cache.
- `fill_way` out 1: way being filled.
- `fill_word` out WB: word index being filled.
- `fill_data` out 32: word being filled.
- `fill_last` out 1: with `fill_we`, the cache writes the tag, sets valid, and clears dirty.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; the refill is complete.

## Operation
- States: IDLE, WB_LOAD, WB_REQ, FILL_REQ, FILL_WR, DONE. A word counter `cnt` (WB bits) is used by both phases.
- IDLE, with `miss_req`=1:
  - Latch `miss_addr`, `victim` as `way_q`, and `victim_tag`. Set `cnt`=0.
  - Go to WB_LOAD if `victim_valid & victim_dirty`, else go to FILL_REQ.
  - The victim inputs are ignored outside this cycle.
- WB_LOAD: drive `cache_rd_word`=`cnt` and capture `cache_rdata` into `wdata_q`. Go to WB_REQ.
- WB_REQ: drive `mem_req`=1, `mem_we`=1, `mem_addr`={latched victim tag, latched index, `cnt`, 2'b00}, `mem_wdata`=`wdata_q`.
  - On `mem_ack`, if `cnt` is last: `cnt`=0, go to FILL_REQ.
  - On `mem_ack`, otherwise: `cnt`+1, go to WB_LOAD.
- FILL_REQ: drive `mem_req`=1, `mem_we`=0, `mem_addr`={latched tag, index, `cnt`, 2'b00} of `miss_addr`.
  - On `mem_ack`, capture `mem_rdata` into `fill_data_q` and go to FILL_WR.
- FILL_WR: drive `fill_we`=1, `fill_way`=`way_q`, `fill_word`=`cnt`, `fill_data`=`fill_data_q`.
  - If `cnt` is last: `fill_last`=1, go to DONE.
  - Otherwise: `cnt`+1, go to FILL_REQ.
- DONE: `done`=1 for one cycle. Go to IDLE.
- Refill is always in word order 0..N-1. There is no critical-word-first.
- `mem_req`, `mem_we`, `mem_addr`, and `mem_wdata` stay stable from the request until the ack cycle, inclusive.
- When not in WB_REQ or FILL_REQ: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- When not in FILL_WR: `fill_*`=0.

## Timing
- Reset: state IDLE and `cnt`=0. Every output reads 0 in the cycle after `rst`: `busy`, `done`, `mem_*`, `fill_*`, `cache_rd_word`.
- `rst` mid-operation aborts to IDLE with no further memory or fill activity.
  - `fill_last` is never issued, so the partially filled line stays invalid.
  - A late `mem_ack` after reset is ignored.
- `busy` rises the cycle after `miss_req` is accepted. It falls in the cycle after the `done` pulse.
- `miss_req` while `busy` is ignored and not queued. If it is still high when the block returns to IDLE, it starts a new miss.
- `mem_ack` is only meaningful while `mem_req`=1. An ack in any other state is ignored.
- With zero-wait memory (`mem_ack` in the request cycle), measured from the acceptance edge:
  - Clean miss: `done` is high 2N+1 cycles after acceptance (N = `WORDS_PER_LINE`).
  - Dirty miss: 4N+1 cycles.
  - Each memory wait cycle adds one cycle.
- A valid, clean victim and an invalid victim (dirty or not) behave identically: no writeback.

## Test plan
- **Clean miss.** Setup: N=8, zero-wait memory; `miss_addr`=0x0000_1A40, `victim`=1, `victim_valid`=1, `victim_dirty`=0. Required: 8 reads to 0x1A40..0x1A5C; `fill_we` on words 0..7 of way 1; `fill_last` on word 7; `done` 17 cycles after acceptance; no `mem_we`.
- **Dirty miss.** Setup: `victim_tag` gives old base 0x0000_3A40, line data 0x100+i. Required: 8 writes of 0x100..0x107 to 0x3A40..0x3A5C strictly before the first read of 0x1A40; `done` after 33 cycles.
- **Invalid-dirty victim.** Setup: `victim_valid`=0, `victim_dirty`=1. Required: no writes, same sequence as the clean miss.
- **Slow memory.** Setup: `mem_ack` 3 cycles after each request. Required: `mem_addr`/`mem_wdata` stay constant across the wait; `done` latency grows by 3 per word.
- **Reset at fill word 4.** Required: next cycle all outputs are 0; `fill_last` never seen; a stray `mem_ack` is ignored; a new `miss_req` is accepted normally.
- **Ignored request.** Stimulus: `miss_req` pulse while busy. Required: ignored, no second sequence. A held `miss_req` restarts the sequence the cycle after `done`.
